bus_initiator: RTL and testbench

BUS_INITIATOR -- requirements
Module: bus_initiator

---
 rtl/bus_initiator.sv | 160 ++++++++++++++++
 tb/tb_bus_initiator.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_initiator.sv
// Single-outstanding bus initiator: a 2-entry request FIFO feeding a
// start/wait/response handshake towards a slave, with a WAIT-state timeout.
module bus_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        bstart,
  output logic        bwrite,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic [31:0] rdata,
  input  logic        bdone,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } cmd_t;

  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  cmd_t        fifo_q [2];
  cmd_t        fifo_d [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  cmd_t        cmd_q, cmd_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        push;
  logic        pop;

  assign req_ready = (count_q != 2'd2);
  assign push      = req_valid && req_ready;
  // The head is only consumed when the bus side is idle, so a pop never
  // coincides with a push into an empty FIFO.
  assign pop       = (state_q == IDLE) && (count_q != 2'd0);

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = {req_write, req_addr, req_wdata, req_wstrb};
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    wait_cnt_d  = wait_cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (count_q != 2'd0) begin
          state_d = START;
          cmd_d   = fifo_q[rd_ptr_q];
        end
      end
      START: begin
        state_d    = WAIT;
        wait_cnt_d = 16'd1;
      end
      WAIT: begin
        // Completion wins over a timeout landing in the same cycle.
        if (bdone) begin
          state_d     = RESP;
          rsp_rdata_d = cmd_q.write ? 32'd0 : rdata;
          rsp_err_d   = 1'b0;
          wait_cnt_d  = 16'd0;
        end else if (wait_cnt_q >= TIMEOUT_LIM) begin
          state_d     = RESP;
          rsp_rdata_d = 32'd0;
          rsp_err_d   = 1'b1;
          wait_cnt_d  = 16'd0;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      for (int i = 0; i < 2; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      cmd_q       <= '0;
      wait_cnt_q  <= 16'd0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cmd_q       <= cmd_d;
      wait_cnt_q  <= wait_cnt_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bstart    = (state_q == START);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign bwrite    = cmd_q.write;
  assign addr      = cmd_q.addr;
  assign wdata     = cmd_q.wdata;
  assign wstrb     = cmd_q.wstrb;
  assign busy      = (state_q != IDLE) || (count_q != 2'd0);

endmodule

// File: tb/tb_bus_initiator.sv
// Bench for bus_initiator: directed transaction table, FIFO backpressure and
// reset sequences, then randomized traffic against a transaction-level model.
module tb_bus_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, rsp_ready, bdone;
  logic [31:0] req_addr, req_wdata, rdata;
  logic [3:0]  req_wstrb;

  logic        m_req_ready, m_rsp_valid, m_rsp_err, m_bstart, m_bwrite, m_busy;
  logic [31:0] m_rsp_rdata, m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic        t_req_ready, t_rsp_valid, t_rsp_err, t_bstart, t_bwrite, t_busy;
  logic [31:0] t_rsp_rdata, t_addr, t_wdata;
  logic [3:0]  t_wstrb;

  logic        o_req_ready, o_rsp_valid, o_rsp_err, o_bstart, o_bwrite, o_busy;
  logic [31:0] o_rsp_rdata, o_addr, o_wdata;
  logic [3:0]  o_wstrb;
  logic        sel4;

  int checks = 0;
  int errors = 0;

  localparam int TMAIN = 8;

  always #5 clk = ~clk;

  bus_initiator #(.TIMEOUT_CYCLES(TMAIN)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(m_req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .rsp_valid(m_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(m_rsp_rdata), .rsp_err(m_rsp_err), .bstart(m_bstart),
    .bwrite(m_bwrite), .addr(m_addr), .wdata(m_wdata), .wstrb(m_wstrb),
    .rdata(rdata), .bdone(bdone), .busy(m_busy)
  );

  bus_initiator #(.TIMEOUT_CYCLES(4)) dut_t4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(t_req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .rsp_valid(t_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(t_rsp_rdata), .rsp_err(t_rsp_err), .bstart(t_bstart),
    .bwrite(t_bwrite), .addr(t_addr), .wdata(t_wdata), .wstrb(t_wstrb),
    .rdata(rdata), .bdone(bdone), .busy(t_busy)
  );

  // Observe either the long-timeout or the 4-cycle-timeout instance.
  assign o_req_ready = sel4 ? t_req_ready : m_req_ready;
  assign o_rsp_valid = sel4 ? t_rsp_valid : m_rsp_valid;
  assign o_rsp_rdata = sel4 ? t_rsp_rdata : m_rsp_rdata;
  assign o_rsp_err   = sel4 ? t_rsp_err   : m_rsp_err;
  assign o_bstart    = sel4 ? t_bstart    : m_bstart;
  assign o_bwrite    = sel4 ? t_bwrite    : m_bwrite;
  assign o_addr      = sel4 ? t_addr      : m_addr;
  assign o_wdata     = sel4 ? t_wdata     : m_wdata;
  assign o_wstrb     = sel4 ? t_wstrb     : m_wstrb;
  assign o_busy      = sel4 ? t_busy      : m_busy;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef struct {
    bit          t4;
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          delay;
    bit          startDone;
    logic [31:0] slvData;
    logic [31:0] expData;
    bit          expErr;
  } vec_t;

  vec_t vecs [8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idleInputs();
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    req_wstrb = 4'd0;
    rsp_ready = 1'b0;
    rdata     = 32'd0;
    bdone     = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    idleInputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic setReq(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_wstrb = s;
  endtask

  // One isolated transaction; the slave answers in WAIT cycle 'delay'
  // (0 = never), so the response lands after min(delay, timeout) WAIT cycles.
  task automatic applyStimulus(input vec_t v, input bit doRst);
    int tmo;
    int waitN;
    sel4  = v.t4;
    tmo   = v.t4 ? 4 : TMAIN;
    waitN = (v.delay == 0) ? tmo : v.delay;
    if (doRst) doReset();
    checkOutput("ready_idle", 32'(o_req_ready), 1);
    setReq(v.write, v.addr, v.wdata, v.wstrb);
    tick();
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'hFFFF_FFFF;
    checkOutput("busy_queued", 32'(o_busy), 1);
    checkOutput("bstart_pre", 32'(o_bstart), 0);
    tick();
    checkOutput("bstart", 32'(o_bstart), 1);
    checkOutput("cmd_addr", o_addr, v.addr);
    checkOutput("cmd_wdata", o_wdata, v.wdata);
    checkOutput("cmd_wstrb", 32'(o_wstrb), 32'(v.wstrb));
    checkOutput("cmd_bwrite", 32'(o_bwrite), 32'(v.write));
    if (v.startDone) begin
      bdone = 1'b1;
      rdata = 32'hBAD0_0000;
    end
    for (int k = 1; k <= waitN; k++) begin
      tick();
      bdone = 1'b0;
      rdata = 32'h0F0F_0F0F;
      checkOutput("bstart_wait", 32'(o_bstart), 0);
      checkOutput("rsp_valid_wait", 32'(o_rsp_valid), 0);
      checkOutput("addr_stable", o_addr, v.addr);
      checkOutput("wdata_stable", o_wdata, v.wdata);
      if (k == v.delay) begin
        bdone = 1'b1;
        rdata = v.slvData;
      end
    end
    tick();
    bdone = 1'b0;
    checkOutput("rsp_valid", 32'(o_rsp_valid), 1);
    checkOutput("rsp_rdata", o_rsp_rdata, v.expData);
    checkOutput("rsp_err", 32'(o_rsp_err), 32'(v.expErr));
    checkOutput("busy_resp", 32'(o_busy), 1);
    bdone = 1'b1;
    rdata = 32'hFFFF_FFFF;
    tick();
    bdone = 1'b0;
    checkOutput("rsp_hold_valid", 32'(o_rsp_valid), 1);
    checkOutput("rsp_hold_rdata", o_rsp_rdata, v.expData);
    checkOutput("rsp_hold_err", 32'(o_rsp_err), 32'(v.expErr));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("rsp_released", 32'(o_rsp_valid), 0);
    checkOutput("busy_done", 32'(o_busy), 0);
    checkOutput("addr_retained", o_addr, v.addr);
    bdone = 1'b1;
    tick();
    bdone = 1'b0;
    checkOutput("idle_bdone_bstart", 32'(o_bstart), 0);
    checkOutput("idle_bdone_valid", 32'(o_rsp_valid), 0);
    checkOutput("idle_bdone_busy", 32'(o_busy), 0);
  endtask

  // Entered on the START cycle of a transaction whose slave replies at once.
  task automatic serveNext(input logic [31:0] expAddr, input logic [31:0] data);
    checkOutput("seq_bstart", 32'(o_bstart), 1);
    checkOutput("seq_addr", o_addr, expAddr);
    tick();
    req_valid = 1'b0;
    bdone = 1'b1;
    rdata = data;
    tick();
    bdone = 1'b0;
    checkOutput("seq_rsp_valid", 32'(o_rsp_valid), 1);
    checkOutput("seq_rsp_rdata", o_rsp_rdata, data);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();
  endtask

  task automatic fifoSequence();
    sel4 = 1'b0;
    doReset();
    setReq(1'b0, 32'hA0, 32'd0, 4'hF);
    checkOutput("fifo_ready_a", 32'(o_req_ready), 1);
    tick();
    setReq(1'b0, 32'hB0, 32'd0, 4'hF);
    checkOutput("fifo_ready_b", 32'(o_req_ready), 1);
    tick();
    checkOutput("fifo_bstart_a", 32'(o_bstart), 1);
    checkOutput("fifo_addr_a", o_addr, 32'hA0);
    setReq(1'b0, 32'hC0, 32'd0, 4'hF);
    checkOutput("fifo_ready_c", 32'(o_req_ready), 1);
    tick();
    setReq(1'b0, 32'hD0, 32'd0, 4'hF);
    checkOutput("fifo_full", 32'(o_req_ready), 0);
    bdone = 1'b1;
    rdata = 32'h1111;
    tick();
    bdone = 1'b0;
    checkOutput("fifo_rsp_a", o_rsp_rdata, 32'h1111);
    checkOutput("fifo_full_resp", 32'(o_req_ready), 0);
    tick();
    checkOutput("fifo_full_hold", 32'(o_req_ready), 0);
    checkOutput("fifo_rsp_held", 32'(o_rsp_valid), 1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("fifo_full_idle", 32'(o_req_ready), 0);
    checkOutput("fifo_valid_gone", 32'(o_rsp_valid), 0);
    tick();
    checkOutput("fifo_ready_d", 32'(o_req_ready), 1);
    serveNext(32'hB0, 32'h2222);
    serveNext(32'hC0, 32'h3333);
    serveNext(32'hD0, 32'h4444);
    checkOutput("fifo_drained", 32'(o_busy), 0);
  endtask

  task automatic resetSequence();
    sel4 = 1'b0;
    doReset();
    setReq(1'b0, 32'h55, 32'd0, 4'hF);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    checkOutput("rst_bstart", 32'(o_bstart), 0);
    checkOutput("rst_rsp_valid", 32'(o_rsp_valid), 0);
    checkOutput("rst_addr", o_addr, 0);
    checkOutput("rst_busy", 32'(o_busy), 0);
    checkOutput("rst_rdata", o_rsp_rdata, 0);
    tick();
    rst = 1'b0;
    bdone = 1'b1;
    rdata = 32'h77;
    tick();
    bdone = 1'b0;
    checkOutput("post_rst_valid", 32'(o_rsp_valid), 0);
    checkOutput("post_rst_busy", 32'(o_busy), 0);
    checkOutput("post_rst_ready", 32'(o_req_ready), 1);
    applyStimulus(vecs[1], 1'b0);
  endtask

  // Transaction-level model: accepted requests queue in order, each start
  // must present the oldest one, and the response time and contents follow
  // from the slave delay chosen here.
  task automatic randomTest(input int cycles);
    req_t        pendQ [$];
    req_t        lastCmd, cur, pushReq;
    bit          pushNext, outstanding, expStart, expValid, inWait, expErr;
    int          startCyc, respCyc, doneAt, d;
    logic [31:0] expData, slvData;
    sel4 = 1'b0;
    doReset();
    lastCmd = '0;
    pushNext = 0; outstanding = 0; expStart = 0; expErr = 0;
    startCyc = 0; respCyc = 0; doneAt = -1;
    expData = 0; slvData = 0;
    for (int cyc = 0; cyc < cycles; cyc++) begin
      if (pushNext) pendQ.push_back(pushReq);
      pushNext = 0;
      checkOutput("rnd_bstart", 32'(o_bstart), 32'(expStart));
      if (expStart && pendQ.size() > 0) begin
        cur = pendQ.pop_front();
        lastCmd = cur;
        outstanding = 1;
        startCyc = cyc;
        d = $urandom_range(0, TMAIN + 2);
        doneAt = (d == 0) ? -1 : cyc + d;
        expErr = (d == 0) || (d > TMAIN);
        respCyc = cyc + (expErr ? TMAIN : d) + 1;
        slvData = $urandom;
        expData = (expErr || cur.write) ? 32'd0 : slvData;
      end
      checkOutput("rnd_addr", o_addr, lastCmd.addr);
      checkOutput("rnd_wdata", o_wdata, lastCmd.wdata);
      checkOutput("rnd_wstrb", 32'(o_wstrb), 32'(lastCmd.wstrb));
      checkOutput("rnd_bwrite", 32'(o_bwrite), 32'(lastCmd.write));
      expValid = outstanding && (cyc >= respCyc);
      checkOutput("rnd_rsp_valid", 32'(o_rsp_valid), 32'(expValid));
      if (expValid) begin
        checkOutput("rnd_rsp_rdata", o_rsp_rdata, expData);
        checkOutput("rnd_rsp_err", 32'(o_rsp_err), 32'(expErr));
      end
      checkOutput("rnd_req_ready", 32'(o_req_ready), 32'(pendQ.size() < 2));
      checkOutput("rnd_busy", 32'(o_busy), 32'(outstanding || pendQ.size() > 0));
      expStart = !outstanding && (pendQ.size() > 0);
      inWait = outstanding && (cyc > startCyc) && (cyc < respCyc);
      rsp_ready = 1'($urandom_range(0, 1));
      if (expValid && rsp_ready) outstanding = 0;
      bdone = (cyc == doneAt) || (!inWait && $urandom_range(0, 7) == 0);
      rdata = (cyc == doneAt) ? slvData : $urandom;
      setReq(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
      req_valid = ($urandom_range(0, 9) < 6);
      if (req_valid && pendQ.size() < 2) begin
        pushNext = 1;
        pushReq = {req_write, req_addr, req_wdata, req_wstrb};
      end
      tick();
    end
    idleInputs();
  endtask

  initial begin
    // t4, write, addr, wdata, wstrb, delay, startDone, slvData, expData, expErr
    vecs[0] = '{1'b0, 1'b0, 32'h10,  32'h0,         4'hF, 1, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'h104, 32'h1234_5678, 4'hF, 5, 1'b0, 32'hAAAA_5555, 32'h0,         1'b0};
    vecs[2] = '{1'b0, 1'b0, 32'h200, 32'h0,         4'h0, 8, 1'b0, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 32'h300, 32'h0,         4'h0, 0, 1'b0, 32'h0,         32'h0,         1'b1};
    vecs[4] = '{1'b1, 1'b0, 32'h400, 32'h0,         4'h0, 0, 1'b0, 32'h0,         32'h0,         1'b1};
    vecs[5] = '{1'b1, 1'b1, 32'h44,  32'hCAFE_0001, 4'h3, 4, 1'b0, 32'h5A5A_5A5A, 32'h0,         1'b0};
    vecs[6] = '{1'b1, 1'b0, 32'h48,  32'h0,         4'h0, 4, 1'b0, 32'h55,        32'h55,        1'b0};
    vecs[7] = '{1'b0, 1'b0, 32'h80,  32'h0,         4'h1, 2, 1'b1, 32'h600D_F00D, 32'h600D_F00D, 1'b0};

    sel4 = 1'b0;
    rst = 1'b1;
    idleInputs();
    tick();
    tick();
    checkOutput("reset_bstart", 32'(o_bstart), 0);
    checkOutput("reset_rsp_valid", 32'(o_rsp_valid), 0);
    checkOutput("reset_rsp_err", 32'(o_rsp_err), 0);
    checkOutput("reset_rsp_rdata", o_rsp_rdata, 0);
    checkOutput("reset_addr", o_addr, 0);
    checkOutput("reset_wdata", o_wdata, 0);
    checkOutput("reset_wstrb", 32'(o_wstrb), 0);
    checkOutput("reset_bwrite", 32'(o_bwrite), 0);
    checkOutput("reset_busy", 32'(o_busy), 0);
    rst = 1'b0;
    tick();
    checkOutput("reset_req_ready", 32'(o_req_ready), 1);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], 1'b1);
    end
    fifoSequence();
    resetSequence();
    randomTest(2000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
